// File: rtl/mem_bridge_pkg.sv
// Shared types and encodings for the IFU/LSU to AXI4-Lite memory bridge.
package mem_bridge_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAr,
      StR,
      StW,
      StB,
      StDone
   } state_e;

   localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
   localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
   localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   localparam logic SRC_IFU = 1'b0;
   localparam logic SRC_LSU = 1'b1;

endpackage

// File: rtl/mem_bridge_if.sv
// Core-side request/response ports plus the AXI4-Lite master channel of the bridge.
interface mem_bridge_if;

   logic        ifu_reqValid;
   logic [31:0] ifu_addr;
   logic        ifu_respValid;
   logic [31:0] ifu_rdata;

   logic        lsu_reqValid;
   logic [31:0] lsu_addr;
   logic [1:0]  lsu_size;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_respValid;
   logic [31:0] lsu_rdata;
   logic        lsu_fault;

   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   // Bridge view.
   modport master (
      input  ifu_reqValid, ifu_addr,
      output ifu_respValid, ifu_rdata,
      input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
      output lsu_respValid, lsu_rdata, lsu_fault,
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   // Core and bus-slave view.
   modport slave (
      output ifu_reqValid, ifu_addr,
      input  ifu_respValid, ifu_rdata,
      output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
      input  lsu_respValid, lsu_rdata, lsu_fault,
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/mem_lane.sv
// Byte-lane steering: write data/strobe shift, read shift and zero-fill, misalignment check.
module mem_lane
   import mem_bridge_pkg::*;
(
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wmask_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o
);

   logic [4:0]  bit_off;
   logic [31:0] rdata_sh;

   always_comb begin
      bit_off      = {addr_i, 3'b000};
      wdata_o      = wdata_i << bit_off;
      wstrb_o      = wmask_i << addr_i;
      rdata_sh     = rdata_i >> bit_off;
      rdata_o      = rdata_sh;
      misaligned_o = 1'b0;
      // The reserved size encoding is treated like a word.
      case (size_i)
         MEM_SIZE_BYTE: rdata_o = {24'h0, rdata_sh[7:0]};
         MEM_SIZE_HALF: begin
            rdata_o      = {16'h0, rdata_sh[15:0]};
            misaligned_o = addr_i[0];
         end
         default: misaligned_o = |addr_i;
      endcase
   end

endmodule

// File: rtl/mem_bridge.sv
// Arbitrates IFU and LSU requests onto one AXI4-Lite master, one transaction outstanding.
module mem_bridge
   import mem_bridge_pkg::*;
(
   input logic          clock,
   input logic          reset,
   mem_bridge_if.master bus
);

   state_e      state_q, state_d;
   logic        src_q, src_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        ifu_resp_q, ifu_resp_d;
   logic        lsu_resp_q, lsu_resp_d;
   logic        lsu_fault_q, lsu_fault_d;
   logic [31:0] ifu_rdata_q, ifu_rdata_d;
   logic [31:0] lsu_rdata_q, lsu_rdata_d;

   logic        lsu_win;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [1:0]  lane_addr, lane_size;
   logic [31:0] lane_wdata, lane_rdata;
   logic [3:0]  lane_wstrb;
   logic        lane_misaligned;

   // The lane sees the incoming request while idle and the latched access afterwards.
   always_comb begin
      lsu_win   = bus.lsu_reqValid;
      req_addr  = lsu_win ? bus.lsu_addr : bus.ifu_addr;
      req_size  = lsu_win ? bus.lsu_size : MEM_SIZE_WORD;
      lane_addr = (state_q == StIdle) ? req_addr[1:0] : addr_q[1:0];
      lane_size = (state_q == StIdle) ? req_size : size_q;
   end

   mem_lane u_lane (
      .addr_i       (lane_addr),
      .size_i       (lane_size),
      .wdata_i      (bus.lsu_wdata),
      .wmask_i      (bus.lsu_wmask),
      .rdata_i      (bus.rdata),
      .wdata_o      (lane_wdata),
      .wstrb_o      (lane_wstrb),
      .rdata_o      (lane_rdata),
      .misaligned_o (lane_misaligned)
   );

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      addr_d      = addr_q;
      size_d      = size_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      ifu_rdata_d = ifu_rdata_q;
      lsu_rdata_d = lsu_rdata_q;
      ifu_resp_d  = 1'b0;
      lsu_resp_d  = 1'b0;
      lsu_fault_d = 1'b0;

      // Response flops are loaded on the transition into StDone so they are live during it.
      unique case (state_q)
         StIdle: begin
            if (bus.lsu_reqValid || bus.ifu_reqValid) begin
               src_d     = lsu_win ? SRC_LSU : SRC_IFU;
               addr_d    = req_addr;
               size_d    = req_size;
               wdata_d   = lane_wdata;
               wstrb_d   = lane_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (lsu_win && lane_misaligned) begin
                  state_d     = StDone;
                  lsu_resp_d  = 1'b1;
                  lsu_fault_d = 1'b1;
                  lsu_rdata_d = 32'h0;
               end else if (lsu_win && bus.lsu_wen) begin
                  state_d = StW;
               end else begin
                  state_d = StAr;
               end
            end
         end
         StAr: begin
            if (bus.arready) state_d = StR;
         end
         StR: begin
            if (bus.rvalid) begin
               state_d = StDone;
               if (src_q == SRC_LSU) begin
                  lsu_resp_d  = 1'b1;
                  lsu_rdata_d = lane_rdata;
                  lsu_fault_d = (bus.rresp != AXI_RESP_OKAY);
               end else begin
                  ifu_resp_d  = 1'b1;
                  ifu_rdata_d = bus.rdata;
               end
            end
         end
         StW: begin
            aw_done_d = aw_done_q | bus.awready;
            w_done_d  = w_done_q | bus.wready;
            if (aw_done_d && w_done_d) state_d = StB;
         end
         StB: begin
            if (bus.bvalid) begin
               state_d     = StDone;
               lsu_resp_d  = 1'b1;
               lsu_rdata_d = 32'h0;
               lsu_fault_d = (bus.bresp != AXI_RESP_OKAY);
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         src_q       <= SRC_IFU;
         addr_q      <= 32'h0;
         size_q      <= MEM_SIZE_BYTE;
         wdata_q     <= 32'h0;
         wstrb_q     <= 4'h0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         ifu_resp_q  <= 1'b0;
         lsu_resp_q  <= 1'b0;
         lsu_fault_q <= 1'b0;
         ifu_rdata_q <= 32'h0;
         lsu_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         ifu_resp_q  <= ifu_resp_d;
         lsu_resp_q  <= lsu_resp_d;
         lsu_fault_q <= lsu_fault_d;
         ifu_rdata_q <= ifu_rdata_d;
         lsu_rdata_q <= lsu_rdata_d;
      end
   end

   assign bus.arvalid       = (state_q == StAr);
   assign bus.araddr        = addr_q;
   assign bus.rready        = (state_q == StR);
   assign bus.awvalid       = (state_q == StW) && !aw_done_q;
   assign bus.awaddr        = addr_q;
   assign bus.wvalid        = (state_q == StW) && !w_done_q;
   assign bus.wdata         = wdata_q;
   assign bus.wstrb         = wstrb_q;
   assign bus.bready        = (state_q == StB);
   assign bus.ifu_respValid = ifu_resp_q;
   assign bus.ifu_rdata     = ifu_rdata_q;
   assign bus.lsu_respValid = lsu_resp_q;
   assign bus.lsu_rdata     = lsu_rdata_q;
   assign bus.lsu_fault     = lsu_fault_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: vector table over a zero-wait slave plus multi-cycle corner cases.
module tb_mem_bridge;

   logic clock = 1'b0;
   logic reset = 1'b1;

   mem_bridge_if bus ();

   mem_bridge dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clock = ~clock;

   typedef struct {
      bit          lsu;
      logic [31:0] addr;
      logic [1:0]  size;
      bit          wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] bus_rdata;
      logic [1:0]  resp;
      int          exp_lat;
      int          exp_bus;    // 0 none, 1 read, 2 write
      logic [31:0] exp_rdata;
      bit          exp_fault;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wstrb;
   } txn_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Slave configuration and monitor state.
   int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   logic [31:0] slv_rdata = 32'h0;
   logic [1:0]  slv_rresp = 2'b00, slv_bresp = 2'b00;
   int          ifu_resp_n, lsu_resp_n, fault_n, first_resp_cyc, ifu_first, lsu_first;
   int          ar_hs_n, aw_hs_n, w_hs_n, traffic_n, b_early_n;
   bit          aw_seen, w_seen;
   logic [31:0] last_ifu_rdata, last_lsu_rdata, cap_araddr, cap_awaddr, cap_wdata;
   logic [3:0]  cap_wstrb;
   logic [31:0] ar_log[$];

   initial forever begin
      @(negedge clock);
      cyc++;
      if (bus.ifu_respValid) begin
         ifu_resp_n++;
         last_ifu_rdata = bus.ifu_rdata;
         if (ifu_first < 0) ifu_first = cyc;
      end
      if (bus.lsu_respValid) begin
         lsu_resp_n++;
         last_lsu_rdata = bus.lsu_rdata;
         if (lsu_first < 0) lsu_first = cyc;
      end
      if ((bus.ifu_respValid || bus.lsu_respValid) && first_resp_cyc < 0) first_resp_cyc = cyc;
      if (bus.lsu_fault) fault_n++;
      if (bus.arvalid || bus.awvalid || bus.wvalid) traffic_n++;
      if (bus.bready && !(aw_seen && w_seen)) b_early_n++;

      if (bus.arvalid) begin bus.arready = (ar_cnt >= ar_wait); ar_cnt++; end
      else begin bus.arready = 1'b0; ar_cnt = 0; end
      if (bus.arvalid && bus.arready) begin
         ar_hs_n++;
         cap_araddr = bus.araddr;
         ar_log.push_back(bus.araddr);
      end
      if (bus.rready) begin bus.rvalid = (r_cnt >= r_wait); r_cnt++; end
      else begin bus.rvalid = 1'b0; r_cnt = 0; end
      bus.rdata = bus.rvalid ? slv_rdata : 32'hDEAD_DEAD;
      bus.rresp = slv_rresp;
      if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_wait); aw_cnt++; end
      else begin bus.awready = 1'b0; aw_cnt = 0; end
      if (bus.awvalid && bus.awready) begin aw_hs_n++; aw_seen = 1'b1; cap_awaddr = bus.awaddr; end
      if (bus.wvalid) begin bus.wready = (w_cnt >= w_wait); w_cnt++; end
      else begin bus.wready = 1'b0; w_cnt = 0; end
      if (bus.wvalid && bus.wready) begin
         w_hs_n++;
         w_seen    = 1'b1;
         cap_wdata = bus.wdata;
         cap_wstrb = bus.wstrb;
      end
      if (bus.bready) begin bus.bvalid = (b_cnt >= b_wait); b_cnt++; end
      else begin bus.bvalid = 1'b0; b_cnt = 0; end
      bus.bresp = slv_bresp;
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      ifu_resp_n = 0; lsu_resp_n = 0; fault_n = 0;
      first_resp_cyc = -1; ifu_first = -1; lsu_first = -1;
      ar_hs_n = 0; aw_hs_n = 0; w_hs_n = 0; traffic_n = 0; b_early_n = 0;
      aw_seen = 1'b0; w_seen = 1'b0;
      ar_log.delete();
   endtask

   // Issues one request from the idle state, holds it until the response, returns latency.
   task automatic run_txn(input txn_t t, output int lat);
      int start;
      int n;
      clear_mon();
      slv_rdata = t.bus_rdata;
      slv_rresp = t.resp;
      slv_bresp = t.resp;
      if (t.lsu) begin
         bus.lsu_reqValid = 1'b1;
         bus.lsu_addr     = t.addr;
         bus.lsu_size     = t.size;
         bus.lsu_wen      = t.wen;
         bus.lsu_wdata    = t.wdata;
         bus.lsu_wmask    = t.wmask;
      end else begin
         bus.ifu_reqValid = 1'b1;
         bus.ifu_addr     = t.addr;
      end
      start = cyc;
      n     = 0;
      while (first_resp_cyc < 0 && n < 40) begin
         tick();
         n++;
      end
      bus.ifu_reqValid = 1'b0;
      bus.lsu_reqValid = 1'b0;
      lat = (first_resp_cyc < 0) ? -1 : first_resp_cyc - start;
      repeat (3) tick();
   endtask

   function automatic txn_t mk(input bit lsu, input logic [31:0] addr, input logic [1:0] size,
                               input bit wen, input logic [31:0] wdata, input logic [3:0] wmask,
                               input logic [31:0] bus_rdata, input logic [1:0] resp,
                               input int exp_lat, input int exp_bus, input logic [31:0] exp_rdata,
                               input bit exp_fault, input logic [31:0] exp_wdata,
                               input logic [3:0] exp_wstrb);
      txn_t t;
      t = '{lsu, addr, size, wen, wdata, wmask, bus_rdata, resp,
            exp_lat, exp_bus, exp_rdata, exp_fault, exp_wdata, exp_wstrb};
      return t;
   endfunction

   txn_t vec[14];

   initial begin
      int   lat;
      int   n;
      int   start;
      txn_t t;

      bus.ifu_reqValid = 1'b0; bus.ifu_addr = 32'h0;
      bus.lsu_reqValid = 1'b0; bus.lsu_addr = 32'h0; bus.lsu_size = 2'd0;
      bus.lsu_wen = 1'b0; bus.lsu_wdata = 32'h0; bus.lsu_wmask = 4'h0;
      clear_mon();

      //          lsu   addr          sz    wen   wdata         mask     bus rdata     resp
      //          lat bus exp_rdata   flt   exp_wdata     exp_wstrb
      vec[0]  = mk(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0010_0093, 2'd0,
                   3, 1, 32'h0010_0093, 1'b0, 32'h0,        4'h0);
      vec[1]  = mk(1'b1, 32'h8000_1003, 2'd0, 1'b0, 32'h0,        4'h0, 32'hAB00_0000, 2'd0,
                   3, 1, 32'h0000_00AB, 1'b0, 32'h0,        4'h0);
      vec[2]  = mk(1'b1, 32'h8000_1002, 2'd1, 1'b0, 32'h0,        4'h0, 32'hBEEF_1234, 2'd0,
                   3, 1, 32'h0000_BEEF, 1'b0, 32'h0,        4'h0);
      vec[3]  = mk(1'b1, 32'h8000_1000, 2'd2, 1'b0, 32'h0,        4'h0, 32'hDEAD_BEEF, 2'd0,
                   3, 1, 32'hDEAD_BEEF, 1'b0, 32'h0,        4'h0);
      vec[4]  = mk(1'b1, 32'h8000_1001, 2'd0, 1'b0, 32'h0,        4'h0, 32'h1122_3344, 2'd0,
                   3, 1, 32'h0000_0033, 1'b0, 32'h0,        4'h0);
      vec[5]  = mk(1'b1, 32'h8000_0002, 2'd2, 1'b0, 32'h0,        4'h0, 32'h5555_5555, 2'd0,
                   1, 0, 32'h0,         1'b1, 32'h0,        4'h0);
      vec[6]  = mk(1'b1, 32'h8000_0001, 2'd1, 1'b0, 32'h0,        4'h0, 32'h5555_5555, 2'd0,
                   1, 0, 32'h0,         1'b1, 32'h0,        4'h0);
      vec[7]  = mk(1'b1, 32'h8000_3000, 2'd2, 1'b0, 32'h0,        4'h0, 32'h1234_5678, 2'd2,
                   3, 1, 32'h1234_5678, 1'b1, 32'h0,        4'h0);
      vec[8]  = mk(1'b1, 32'h8000_2001, 2'd0, 1'b1, 32'h0000_00A5, 4'h1, 32'h0,       2'd0,
                   3, 2, 32'h0,         1'b0, 32'h0000_A500, 4'h2);
      vec[9]  = mk(1'b1, 32'h8000_2000, 2'd2, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0,       2'd0,
                   3, 2, 32'h0,         1'b0, 32'hCAFE_F00D, 4'hF);
      vec[10] = mk(1'b1, 32'h8000_2004, 2'd2, 1'b1, 32'h0123_4567, 4'hF, 32'h0,       2'd2,
                   3, 2, 32'h0,         1'b1, 32'h0123_4567, 4'hF);
      vec[11] = mk(1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'h0,        4'h0, 32'h0000_0013, 2'd2,
                   3, 1, 32'h0000_0013, 1'b0, 32'h0,        4'h0);
      vec[12] = mk(1'b1, 32'h8000_2003, 2'd0, 1'b1, 32'h1234_5677, 4'h1, 32'h0,       2'd0,
                   3, 2, 32'h0,         1'b0, 32'h7700_0000, 4'h8);
      vec[13] = mk(1'b1, 32'h8000_2003, 2'd1, 1'b1, 32'h1234_5677, 4'h3, 32'h0,       2'd0,
                   1, 0, 32'h0,         1'b1, 32'h0,        4'h0);

      // Reset state.
      repeat (3) tick();
      check("reset ctrl outputs", {24'h0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
            bus.bready, bus.ifu_respValid, bus.lsu_respValid, bus.lsu_fault}, 32'h0);
      check("reset ifu_rdata", bus.ifu_rdata, 32'h0);
      check("reset lsu_rdata", bus.lsu_rdata, 32'h0);
      check("reset araddr", bus.araddr, 32'h0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 14; i++) begin
         run_txn(vec[i], lat);
         check($sformatf("v%0d latency", i), lat, vec[i].exp_lat);
         if (vec[i].lsu) begin
            check($sformatf("v%0d lsu resp count", i), lsu_resp_n, 1);
            check($sformatf("v%0d ifu resp count", i), ifu_resp_n, 0);
            check($sformatf("v%0d lsu_rdata", i), last_lsu_rdata, vec[i].exp_rdata);
         end else begin
            check($sformatf("v%0d ifu resp count", i), ifu_resp_n, 1);
            check($sformatf("v%0d lsu resp count", i), lsu_resp_n, 0);
            check($sformatf("v%0d ifu_rdata", i), last_ifu_rdata, vec[i].exp_rdata);
         end
         check($sformatf("v%0d fault pulses", i), fault_n, {31'h0, vec[i].exp_fault});
         case (vec[i].exp_bus)
            0: check($sformatf("v%0d bus traffic", i), traffic_n, 0);
            1: begin
               check($sformatf("v%0d ar handshakes", i), ar_hs_n, 1);
               check($sformatf("v%0d araddr", i), cap_araddr, vec[i].addr);
               check($sformatf("v%0d write handshakes", i), aw_hs_n + w_hs_n, 0);
            end
            default: begin
               check($sformatf("v%0d aw handshakes", i), aw_hs_n, 1);
               check($sformatf("v%0d w handshakes", i), w_hs_n, 1);
               check($sformatf("v%0d awaddr", i), cap_awaddr, vec[i].addr);
               check($sformatf("v%0d wdata", i), cap_wdata, vec[i].exp_wdata);
               check($sformatf("v%0d wstrb", i), {28'h0, cap_wstrb}, {28'h0, vec[i].exp_wstrb});
               check($sformatf("v%0d ar handshakes", i), ar_hs_n, 0);
            end
         endcase
      end

      // Half store with wready two cycles after awready.
      w_wait = 2;
      t = mk(1'b1, 32'h8000_1002, 2'd1, 1'b1, 32'h1234_BEEF, 4'b0011, 32'h0, 2'd0,
             5, 2, 32'h0, 1'b0, 32'hBEEF_0000, 4'b1100);
      run_txn(t, lat);
      check("slow w latency", lat, 5);
      check("slow w wdata", cap_wdata, 32'hBEEF_0000);
      check("slow w wstrb", {28'h0, cap_wstrb}, 32'hC);
      check("slow w early bready", b_early_n, 0);
      check("slow w aw/w handshakes", aw_hs_n * 16 + w_hs_n, 32'h11);
      check("slow w resp count", lsu_resp_n, 1);
      w_wait = 0;

      // Word store with awready late instead.
      aw_wait = 2;
      t = mk(1'b1, 32'h8000_1004, 2'd2, 1'b1, 32'hA5A5_0F0F, 4'hF, 32'h0, 2'd0,
             5, 2, 32'h0, 1'b0, 32'hA5A5_0F0F, 4'hF);
      run_txn(t, lat);
      check("slow aw latency", lat, 5);
      check("slow aw early bready", b_early_n, 0);
      check("slow aw awaddr", cap_awaddr, 32'h8000_1004);
      aw_wait = 0;

      // Simultaneous requests, both held one cycle past their own response.
      clear_mon();
      slv_rdata = 32'h0102_0304; slv_rresp = 2'd0; slv_bresp = 2'd0;
      bus.lsu_reqValid = 1'b1; bus.lsu_addr = 32'h8000_4000; bus.lsu_size = 2'd2;
      bus.lsu_wen = 1'b0;
      bus.ifu_reqValid = 1'b1; bus.ifu_addr = 32'h8000_000C;
      start = cyc;
      n = 0;
      while (!(ifu_first >= 0 && cyc > ifu_first) && n < 40) begin
         tick();
         n++;
         if (lsu_first >= 0 && cyc > lsu_first) bus.lsu_reqValid = 1'b0;
      end
      bus.ifu_reqValid = 1'b0;
      bus.lsu_reqValid = 1'b0;
      repeat (4) tick();
      check("arb lsu resp cycle", lsu_first - start, 3);
      check("arb ifu resp cycle", ifu_first - start, 7);
      check("arb lsu resp count", lsu_resp_n, 1);
      check("arb ifu resp count", ifu_resp_n, 1);
      check("arb ar count", ar_log.size(), 2);
      check("arb first araddr", (ar_log.size() > 0) ? ar_log[0] : 32'h0, 32'h8000_4000);
      check("arb second araddr", (ar_log.size() > 1) ? ar_log[1] : 32'h0, 32'h8000_000C);
      check("arb lsu_rdata", last_lsu_rdata, 32'h0102_0304);
      check("arb ifu_rdata", last_ifu_rdata, 32'h0102_0304);

      // Reset while waiting in R for an rvalid that never comes.
      r_wait = 1000;
      clear_mon();
      bus.ifu_reqValid = 1'b1; bus.ifu_addr = 32'h8000_0010;
      n = 0;
      while (!bus.rready && n < 20) begin
         tick();
         n++;
      end
      check("rst reached R", {31'h0, bus.rready}, 32'h1);
      reset = 1'b1;
      bus.ifu_reqValid = 1'b0;
      tick();
      check("rst ctrl outputs", {24'h0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
            bus.bready, bus.ifu_respValid, bus.lsu_respValid, bus.lsu_fault}, 32'h0);
      check("rst ifu_rdata", bus.ifu_rdata, 32'h0);
      check("rst lsu_rdata", bus.lsu_rdata, 32'h0);
      check("rst araddr", bus.araddr, 32'h0);
      check("rst wdata/wstrb", bus.wdata | {28'h0, bus.wstrb}, 32'h0);
      reset  = 1'b0;
      r_wait = 0;
      t = mk(1'b0, 32'h8000_0014, 2'd2, 1'b0, 32'h0, 4'h0, 32'h0000_A0B7, 2'd0,
             3, 1, 32'h0000_A0B7, 1'b0, 32'h0, 4'h0);
      run_txn(t, lat);
      check("post-rst latency", lat, 3);
      check("post-rst ifu_rdata", last_ifu_rdata, 32'h0000_A0B7);
      check("post-rst araddr", cap_araddr, 32'h8000_0014);
      check("post-rst ifu resp count", ifu_resp_n, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Sits directly downstream of the multi-cycle core's fetch and load/store ports. Arbitrates the IFU and LSU request/response interfaces onto one AXI4-Lite master port. Performs byte-lane alignment for sub-word accesses and detects misaligned accesses. Allows exactly one bus transaction outstanding.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clock` in 1: single clock; every register in the block is clocked on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ifu_reqValid` in 1, `ifu_addr` in 32: fetch request. The core holds both until `ifu_respValid`.
- `ifu_respValid` out 1, `ifu_rdata` out 32: one-cycle response pulse. `ifu_rdata` holds its value until the next fetch response.
- `lsu_reqValid` in 1, `lsu_addr` in 32, `lsu_size` in 2, `lsu_wen` in 1, `lsu_wdata` in 32, `lsu_wmask` in 4: load/store request.
  - Size encoding: 0 = byte, 1 = half, 2 = word.
  - `lsu_wdata` and `lsu_wmask` arrive unshifted, lane 0 based.
- `lsu_respValid` out 1, `lsu_rdata` out 32: one-cycle pulse. `lsu_rdata` is right-aligned, zero-filled above the access size, and held until the next LSU response.
- `lsu_fault` out 1: pulses together with `lsu_respValid` on a misaligned access or a nonzero `rresp`/`bresp`.
- AXI4-Lite master ports:
  - `araddr` out 32, `arvalid` out 1, `arready` in 1
  - `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1
  - `awaddr` out 32, `awvalid` out 1, `awready` in 1
  - `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1
  - `bresp` in 2, `bvalid` in 1, `bready` out 1

## Operation
- States: IDLE, AR, R, W, B, DONE.
- IDLE: samples the request lines.
  - LSU wins over IFU when both are high.
  - The winner's address, size, wen, shifted wdata and shifted mask are latched, plus a source bit.
- Transitions out of IDLE:
  - Misaligned LSU request → DONE with fault set, no bus traffic. Misaligned means half with `addr[0]=1`, or word with `addr[1:0]≠0`.
  - Otherwise read (IFU, or LSU with `wen=0`) → AR; write → W.
- IFU addresses are assumed word-aligned; their low bits are forwarded unchanged.
- AR: `arvalid=1` and `araddr` equals the latched address, both stable until `arready`. Go to R on handshake.
- R: `rready=1`. On `rvalid`, capture the read data and flag `rresp≠0`, then go to DONE.
- W: `awvalid` and `wvalid` rise together.
  - Each drops independently after its own handshake.
  - Go to B once both are done; the handshakes may occur in either order or the same cycle.
  - `wdata = lsu_wdata << (8*addr[1:0])`.
  - `wstrb = lsu_wmask << addr[1:0]`, truncated to 4 bits.
- B: `bready=1`. On `bvalid`, flag `bresp≠0` and go to DONE.
- DONE: lasts exactly one cycle.
  - Pulses `respValid` of the latched source and loads its `rdata` register.
  - LSU read data = `(bus_rdata >> 8*addr[1:0])` masked to byte, half or word.
  - LSU write responses drive `lsu_rdata = 0`.
  - A fault on an LSU access pulses `lsu_fault`.
  - A fault on an IFU access is dropped; the data is still returned.
  - Request lines are ignored in DONE, so a request still held high cannot be re-accepted.
- Reset (in any state, including mid-transaction):
  - State goes to IDLE.
  - All valid, ready and response outputs go to 0; `ifu_rdata` and `lsu_rdata` go to 0.
  - The outstanding transaction is abandoned; the bus slave is reset in the same cycle.

## Timing
- Reset values: every output is 0.
- Latency from the accepting IDLE cycle to `respValid` is 3 cycles with zero-wait slave responses: IDLE → AR → R → DONE (W → B → DONE for writes). Each slave wait cycle adds one.
- Misaligned access: `respValid` and `lsu_fault` arrive 1 cycle after acceptance.
- Back-to-back throughput: the earliest next acceptance is the cycle after DONE, so a minimum of 4 cycles per access.
- All AXI outputs are registered or decoded from state only; there are no combinational paths from AXI inputs to AXI outputs.

## Structure
- Package `mem_bridge_pkg` holds:
  - the state enum;
  - `MEM_SIZE_BYTE/HALF/WORD`;
  - `AXI_RESP_OKAY`;
  - the source encoding `SRC_IFU/SRC_LSU`.
- One combinational sub-module, `mem_lane`, performs the write shift/strobe, the read shift/mask and the misalignment check. The parent holds the state machine and latches.

## Test plan
- **IFU fetch:** `ifu_addr=0x80000004`, slave with `arready=1` returns `rdata=0x00100093` one cycle later → `araddr=0x80000004`, `ifu_respValid` pulses 3 cycles after acceptance, `ifu_rdata=0x00100093`.
- **LSU byte load:** `lsu_addr=0x80001003`, size=0; bus `rdata=0xAB000000` → `lsu_rdata=0x000000AB`, `lsu_fault=0`.
- **LSU half store:** `addr=0x80001002`, `wdata=0x1234BEEF`, `wmask=4'b0011` → `wdata=0xBEEF0000`, `wstrb=4'b1100`. Slave gives `wready` 2 cycles after `awready`; B is entered only after both handshakes, and `lsu_respValid` pulses once.
- **Misaligned word load:** `addr=0x80000002` → no `arvalid`; `lsu_respValid` and `lsu_fault` pulse 1 cycle later with `lsu_rdata=0`.
- **Simultaneous requests:** IFU and LSU requests in the same cycle → LSU is served first; IFU is accepted the cycle after DONE. A request held high through DONE produces exactly one response.
- **Reset mid-transaction:** assert reset in state R with `rvalid` never given → next cycle all outputs are 0. After reset is released, a fresh fetch completes normally.
